// File: rtl/downcount_timer_ctrl.sv
// Prescaled down-counter with one-shot / auto-reload modes, pause and abort.
// Priority at every edge is abort > start > pause; all outputs are registered.
module downcount_timer_ctrl #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             pause,
  input  logic             abort,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q_out,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

  state_t           state_q;
  logic [7:0]       presc_q;
  logic [7:0]       presc_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_dec_d;
  logic [WIDTH-1:0] reload_q;
  logic             ar_q;
  logic             tc_q;
  logic             busy_q;
  logic             done_q;
  logic             tick_s;

  assign tick_s      = (presc_q == PRESC_LAST);
  assign presc_d     = tick_s ? 8'd0 : (presc_q + 8'd1);
  assign count_dec_d = count_q - WIDTH'(1);

  // Timer FSM with registered count, flags and terminal-count pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      presc_q  <= 8'd0;
      count_q  <= {WIDTH{1'b0}};
      reload_q <= {WIDTH{1'b0}};
      ar_q     <= 1'b0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (abort) begin
        state_q <= ST_IDLE;
        presc_q <= 8'd0;
        count_q <= {WIDTH{1'b0}};
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              count_q  <= load_val;
              reload_q <= load_val;
              ar_q     <= auto_reload;
              presc_q  <= 8'd0;
              // A zero load completes immediately, even in periodic mode.
              if (load_val == {WIDTH{1'b0}}) begin
                state_q <= ST_DONE;
                tc_q    <= 1'b1;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= ST_RUN;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
              end
            end else begin
              state_q <= state_q;
            end
          end
          ST_RUN: begin
            if (pause) begin
              state_q <= ST_PAUSE;
            end else begin
              presc_q <= presc_d;
              if (tick_s) begin
                if (count_q != {WIDTH{1'b0}}) begin
                  count_q <= count_dec_d;
                  if (count_dec_d == {WIDTH{1'b0}}) begin
                    tc_q <= 1'b1;
                    if (!ar_q) begin
                      state_q <= ST_DONE;
                      busy_q  <= 1'b0;
                      done_q  <= 1'b1;
                    end else begin
                      state_q <= ST_RUN;
                    end
                  end else begin
                    state_q <= ST_RUN;
                  end
                end else begin
                  count_q <= reload_q;
                end
              end else begin
                state_q <= ST_RUN;
              end
            end
          end
          ST_PAUSE: begin
            if (!pause) begin
              state_q <= ST_RUN;
            end else begin
              state_q <= ST_PAUSE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign q_out = count_q;
  assign busy  = busy_q;
  assign tc    = tc_q;
  assign done  = done_q;

endmodule

// File: tb/tb_downcount_timer_ctrl.sv
// Scoreboard bench: two timers (PRESCALE 1 and 4) share stimulus; a behavioural
// model predicts each edge's outputs and a monitor compares them after the edge.
module tb_downcount_timer_ctrl;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] q;
    logic         busy;
    logic         tc;
    logic         done;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } exp_t;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] load_val;
  logic         pause;
  logic         abort;
  logic         auto_reload;
  logic [W-1:0] q1, q4;
  logic         busy1, busy4, tc1, tc4, done1, done4;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb[$];

  int m_mode[2];
  int m_cnt[2];
  int m_ph[2];
  int m_rel[2];
  bit m_ar[2];
  bit m_tc[2];
  int m_p[2] = '{1, 4};

  downcount_timer_ctrl #(.WIDTH(W), .PRESCALE(1)) u_p1 (
    .clk(clk), .reset_n(reset_n), .start(start), .load_val(load_val),
    .pause(pause), .abort(abort), .auto_reload(auto_reload),
    .q_out(q1), .busy(busy1), .tc(tc1), .done(done1)
  );

  downcount_timer_ctrl #(.WIDTH(W), .PRESCALE(4)) u_p4 (
    .clk(clk), .reset_n(reset_n), .start(start), .load_val(load_val),
    .pause(pause), .abort(abort), .auto_reload(auto_reload),
    .q_out(q4), .busy(busy4), .tc(tc4), .done(done4)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = M_IDLE; m_cnt[i] = 0; m_ph[i] = 0;
      m_rel[i] = 0; m_ar[i] = 1'b0; m_tc[i] = 1'b0;
    end
  endtask

  // One rising edge of timer i: abort wins, then start from idle/done, then pause.
  task automatic model_step(input int i, input bit st, input int lv,
                            input bit pa, input bit ab, input bit ar);
    m_tc[i] = 1'b0;
    if (ab) begin
      m_mode[i] = M_IDLE; m_cnt[i] = 0; m_ph[i] = 0;
    end else if (st && (m_mode[i] == M_IDLE || m_mode[i] == M_DONE)) begin
      m_cnt[i] = lv; m_rel[i] = lv; m_ar[i] = ar; m_ph[i] = 0;
      if (lv == 0) begin
        m_mode[i] = M_DONE; m_tc[i] = 1'b1;
      end else begin
        m_mode[i] = M_RUN;
      end
    end else if (m_mode[i] == M_RUN && pa) begin
      m_mode[i] = M_PAUSE;
    end else if (m_mode[i] == M_PAUSE) begin
      if (!pa) m_mode[i] = M_RUN;
    end else if (m_mode[i] == M_RUN) begin
      m_ph[i] = m_ph[i] + 1;
      if (m_ph[i] == m_p[i]) begin
        m_ph[i] = 0;
        if (m_cnt[i] > 0) begin
          m_cnt[i] = m_cnt[i] - 1;
          if (m_cnt[i] == 0) begin
            m_tc[i] = 1'b1;
            if (!m_ar[i]) m_mode[i] = M_DONE;
          end
        end else begin
          m_cnt[i] = m_rel[i];
        end
      end
    end
  endtask

  function automatic obs_t model_obs(input int i);
    obs_t o;
    o.q    = W'(m_cnt[i]);
    o.busy = (m_mode[i] == M_RUN) || (m_mode[i] == M_PAUSE);
    o.tc   = m_tc[i];
    o.done = (m_mode[i] == M_DONE);
    return o;
  endfunction

  task automatic drive(input bit st, input int lv, input bit pa, input bit ab, input bit ar);
    exp_t e;
    @(negedge clk);
    start = st; load_val = W'(lv); pause = pa; abort = ab; auto_reload = ar;
    model_step(0, st, lv, pa, ab, ar);
    model_step(1, st, lv, pa, ab, ar);
    e.a = model_obs(0);
    e.b = model_obs(1);
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Outputs must clear asynchronously, with no clock edge in between.
  task automatic reset_pulse();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_q1", int'(q1), 0);       chk("rst_busy1", int'(busy1), 0);
    chk("rst_tc1", int'(tc1), 0);     chk("rst_done1", int'(done1), 0);
    chk("rst_q4", int'(q4), 0);       chk("rst_busy4", int'(busy4), 0);
    chk("rst_tc4", int'(tc4), 0);     chk("rst_done4", int'(done4), 0);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  // Monitor: compares the prediction for the edge just taken.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("p1_q", int'(q1), int'(e.a.q));       chk("p1_busy", int'(busy1), int'(e.a.busy));
      chk("p1_tc", int'(tc1), int'(e.a.tc));    chk("p1_done", int'(done1), int'(e.a.done));
      chk("p4_q", int'(q4), int'(e.b.q));       chk("p4_busy", int'(busy4), int'(e.b.busy));
      chk("p4_tc", int'(tc4), int'(e.b.tc));    chk("p4_done", int'(done4), int'(e.b.done));
    end
  end

  initial begin
    reset_n = 1'b0; start = 1'b1; load_val = 4'd7;
    pause = 1'b0; abort = 1'b0; auto_reload = 1'b0;
    model_reset();
    #4;
    chk("init_q", int'(q1), 0);       chk("init_busy", int'(busy1), 0);
    chk("init_done", int'(done1), 0); chk("init_tc", int'(tc1), 0);
    #1;
    reset_n = 1'b1; start = 1'b0;

    // one-shot count 5..0 then held in DONE
    drive(1'b1, 5, 1'b0, 1'b0, 1'b0);
    idle(8);
    // periodic mode, 3..0 repeating; start while running is ignored
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 3, 1'b0, 1'b0, 1'b1);
    idle(5);
    drive(1'b1, 12, 1'b0, 1'b0, 1'b0);
    idle(8);
    // pause held on the three edges after q reaches 6
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 9, 1'b0, 1'b0, 1'b0);
    idle(3);
    for (int k = 0; k < 3; k++) drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle(8);
    // abort at 4, then zero load, then abort+start together in IDLE
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 7, 1'b0, 1'b0, 1'b0);
    idle(3);
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 0, 1'b0, 1'b0, 1'b1);
    idle(2);
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 6, 1'b0, 1'b1, 1'b0);
    idle(2);
    // PRESCALE=4 instance: 2 for 4 clocks, 1 for 4 clocks, then 0
    drive(1'b1, 2, 1'b0, 1'b0, 1'b0);
    idle(10);
    drive(1'b1, 9, 1'b0, 1'b0, 1'b0);
    idle(2);
    reset_pulse();
    idle(2);

    for (int n = 0; n < 400; n++) begin
      drive(($urandom % 4) == 0, int'($urandom % 16), ($urandom % 5) == 0,
            ($urandom % 25) == 0, ($urandom % 2) == 1);
      if (n == 200) reset_pulse();
    end

    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/downcount_timer_ctrl.md
DOWNCOUNT_TIMER_CTRL -- requirements
Module: downcount_timer_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: counter width in bits.
REQ-002 The block SHALL have parameter PRESCALE, default 1: clocks per decrement; legal range 1 to 255.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: load load_val and begin counting.
REQ-006 The block SHALL have port load_val, input, WIDTH bits: start value, sampled only on an accepted start.
REQ-007 The block SHALL have port pause, input, 1 bit: level; freeze counting while high.
REQ-008 The block SHALL have port abort, input, 1 bit: cancel the current operation and return to IDLE.
REQ-009 The block SHALL have port auto_reload, input, 1 bit: sampled on an accepted start; 1 selects periodic mode.
REQ-010 The block SHALL have port q_out, output, WIDTH bits: current count, registered.
REQ-011 The block SHALL have port busy, output, 1 bit: high in RUN or PAUSE.
REQ-012 The block SHALL have port tc, output, 1 bit: terminal-count pulse, registered.
REQ-013 The block SHALL have port done, output, 1 bit: high in DONE.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, PAUSE and DONE; encoding is free.
REQ-015 Input priority SHALL be abort > start > pause, evaluated at each rising edge.
REQ-016 In IDLE or DONE, start=1 (abort=0) SHALL take effect at that edge:
- q_out <= load_val; reload_reg <= load_val; ar_reg <= auto_reload
- prescale counter <= 0; done <= 0
- next state RUN, or DONE if load_val==0
REQ-017 A start with load_val==0 SHALL enter DONE with q_out=0 and tc high for that one cycle, regardless of auto_reload.
REQ-018 In RUN with pause=0, the prescale counter SHALL increment each clock; at PRESCALE-1 it SHALL clear and generate a tick.
REQ-019 On a tick with q_out>0, q_out SHALL decrement by 1.
REQ-020 When q_out becomes 0, tc SHALL be high for exactly that first cycle of q_out==0.
REQ-021 With ar_reg=0, reaching 0 SHALL move the FSM to DONE at the same edge: busy=0, done=1, q_out held at 0.
REQ-022 With ar_reg=1, the FSM SHALL stay in RUN, and the next tick at q_out==0 SHALL load reload_reg; the period is (reload_reg+1)*PRESCALE clocks.
REQ-023 Pause SHALL work as follows:
- pause=1 in RUN: next state PAUSE; no tick at that edge.
- In PAUSE: q_out and the prescale counter SHALL be frozen.
- pause=0 in PAUSE: next state RUN; no tick at that edge.
REQ-024 start in RUN or PAUSE SHALL be ignored; counting is not restarted.
REQ-025 abort=1 in RUN, PAUSE or DONE SHALL cause the following at the next edge:
- next state IDLE
- q_out <= 0; busy, done, tc <= 0
- prescale counter <= 0
- no tc generated
REQ-026 abort and start together in IDLE SHALL leave the block in IDLE with q_out unchanged.
REQ-027 q_out SHALL never wrap below 0; the full load_val range 0 to 2^WIDTH-1 is legal.
REQ-028 busy and done SHALL be registered and mutually exclusive.

Reset
REQ-029 reset_n=0 SHALL immediately, without waiting for a clock edge, force:
- state IDLE; q_out=0; busy=0; tc=0; done=0
- prescale counter=0; reload_reg=0; ar_reg=0
REQ-030 Reset asserted mid-count SHALL discard the operation; after release the block SHALL wait in IDLE for a new start.
REQ-031 All inputs SHALL be ignored while reset_n=0.

Verification
REQ-032 The bench SHALL cover: reset_n=0 from t=0 with clk toggling every 10 ns and start=1 -> q_out=0, busy=0, done=0, tc=0 until release at 5 ns.
REQ-033 The bench SHALL cover: PRESCALE=1, load_val=5, single-cycle start -> q_out 5,4,3,2,1,0 on successive edges; tc high only with the first 0; then done=1, busy=0, q_out held at 0.
REQ-034 The bench SHALL cover: auto_reload=1, load_val=3 -> q_out 3,2,1,0,3,2,1,0...; tc every 4 clocks; done stays 0; busy stays 1.
REQ-035 The bench SHALL cover: load_val=9; pause sampled high on the 3 edges after q_out becomes 6 -> q_out=6 for 5 clock periods, then 5,4...
REQ-036 The bench SHALL cover: abort while q_out=4 -> next edge q_out=0, busy=0, tc=0. Then start with load_val=0 -> DONE, tc high for 1 cycle.
REQ-037 The bench SHALL cover: PRESCALE=4, load_val=2 -> q_out holds 2 for 4 clocks, then 1 for 4 clocks, then 0. Then reset_n pulsed low between edges -> outputs clear before the next edge.
